alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose:
//   Arbitrates two requesters onto one shared, purely combinational ALU.
//   Each accepted operation walks IDLE -> EXEC -> RESP: the operands and
//   opcode are captured on acceptance, the ALU is driven for exactly one
//   cycle in EXEC, and the registered result is offered on the response
//   port until it is taken. At most one operation is in flight.
//
// Configuration:
//   ALU_ARBITER_ROUND_ROBIN_EN  defined  : round-robin between the two
//                                          requesters when both are valid.
//                               undefined: fixed priority, port 0 wins.
//
// Ports:
//   clk                  clock, all state on the rising edge
//   reset                synchronous, active-low reset
//   reqN_valid/op/a/b    requester N operation (op: 0 ADD, 1 SUB, 2 AND,
//                        3 OR, 4 XOR, 5 INV, 6 CLR, 7 illegal)
//   reqN_ready           high only for the granted requester, only in IDLE
//   alu_ctrl             one-hot {CLR,INV,XOR,OR,AND,SUB,ADD}, EXEC only
//   alu_in1/alu_in2      latched operands to the ALU
//   alu_out/alu_overflow combinational ALU result and flag
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/data/overflow/err  response payload (err = illegal opcode)

module alu_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [2:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [2:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic [6:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_overflow,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic                    id_q, id_d;
  logic [DATA_WIDTH-1:0]   in1_q, in1_d;
  logic [DATA_WIDTH-1:0]   in2_q, in2_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_overflow_q, rsp_overflow_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    grant0, grant1;
  logic                    accept_en;
  logic                    illegal_op;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // Port that won the most recent acceptance; 1 after reset so port 0
  // wins the first contended grant.
  logic                    last_grant_q, last_grant_d;
`endif

  // Grant selection. A lone valid requester always wins; only the
  // contended case depends on the arbitration policy.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
`else
      grant0 = 1'b1;
      grant1 = 1'b0;
`endif
    end
  end

  // Ready is gated by reset so nothing is accepted during a reset cycle.
  assign accept_en  = reset && (state_q == IDLE);
  assign req0_ready = accept_en && grant0;
  assign req1_ready = accept_en && grant1;

  assign illegal_op = (op_q == OP_ILLEGAL);

  // ALU control is only asserted while executing; the illegal opcode is
  // steered onto CLR so the ALU produces a harmless result.
  always_comb begin
    alu_ctrl = 7'b0000000;
    if (state_q == EXEC) begin
      if (illegal_op) begin
        alu_ctrl = 7'b1000000;
      end else begin
        alu_ctrl = 7'(1) << op_q;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    id_d           = id_q;
    in1_d          = in1_q;
    in2_d          = in2_q;
    rsp_id_d       = rsp_id_q;
    rsp_data_d     = rsp_data_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_err_d      = rsp_err_q;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    last_grant_d   = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          op_d    = req0_op;
          in1_d   = req0_a;
          in2_d   = req0_b;
          id_d    = 1'b0;
          state_d = EXEC;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end else if (req1_ready) begin
          op_d    = req1_op;
          in1_d   = req1_a;
          in2_d   = req1_b;
          id_d    = 1'b1;
          state_d = EXEC;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end
      end

      EXEC: begin
        // Capture the ALU result at the end of the single EXEC cycle.
        rsp_id_d       = id_q;
        rsp_err_d      = illegal_op;
        rsp_data_d     = illegal_op ? '0 : alu_out;
        rsp_overflow_d = illegal_op ? 1'b0 : alu_overflow;
        state_d        = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      op_q           <= 3'd0;
      id_q           <= 1'b0;
      in1_q          <= '0;
      in2_q          <= '0;
      rsp_id_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      id_q           <= id_d;
      in1_q          <= in1_d;
      in2_q          <= in2_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_err_q      <= rsp_err_d;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with a small
// combinational ALU model attached to the ALU-side ports.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [6:0] alu_ctrl;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic       alu_overflow;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_err;
  logic [7:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  // ALU model; outputs junk when no control bit is set so a result
  // captured at the wrong time shows up.
  always_comb begin
    alu_out      = 8'hA5;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      7'b0000001: {alu_overflow, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      7'b0000010: {alu_overflow, alu_out} = {1'b0, alu_in1} - {1'b0, alu_in2};
      7'b0000100: begin alu_out = alu_in1 & alu_in2; alu_overflow = 1'b0; end
      7'b0001000: begin alu_out = alu_in1 | alu_in2; alu_overflow = 1'b0; end
      7'b0010000: begin alu_out = alu_in1 ^ alu_in2; alu_overflow = 1'b0; end
      7'b0100000: begin alu_out = ~alu_in1;          alu_overflow = 1'b0; end
      7'b1000000: begin alu_out = 8'h00;             alu_overflow = 1'b0; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Present a request and step to just after its acceptance edge.
  task automatic wait_accept(input logic port);
    int n;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant", port ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic port, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [6:0] ectrl, input logic [7:0] edata,
                       input logic eov, input logic eerr);
    @(negedge clk);
    drive_req(port, op, a, b);
    #1;
    wait_accept(port);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_ctrl", alu_ctrl, ectrl);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_in1", alu_in1, a);
    chk("exec_in2", alu_in2, b);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, port);
    chk("rsp_data", rsp_data, edata);
    chk("rsp_overflow", rsp_overflow, eov);
    chk("rsp_err", rsp_err, eerr);
    chk("resp_ctrl_zero", alu_ctrl, 0);
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
    $display("op port=%0d op=%0d a=%h b=%h -> data=%h ov=%b err=%b id=%b",
             port, op, a, b, edata, eov, eerr, port);
  endtask

  typedef struct {
    logic       port;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] ctrl;
    logic [7:0] data;
    logic       ov;
    logic       err;
  } vec_t;

  vec_t vecs[10];
  logic exp_ids[4];
  logic got_ids[4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, n;
    vecs[0] = '{1'b0, 3'd0, 8'h0F, 8'h01, 7'b0000001, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 8'hFF, 8'h02, 7'b0000001, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 3'd1, 8'h01, 8'h02, 7'b0000010, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd1, 8'h05, 8'h03, 7'b0000010, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd2, 8'hF0, 8'h3C, 7'b0000100, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 8'hF0, 8'h0F, 7'b0001000, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 3'd4, 8'hAA, 8'hFF, 7'b0010000, 8'h55, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 3'd5, 8'h3C, 8'h00, 7'b0100000, 8'hC3, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 3'd6, 8'h12, 8'h34, 7'b1000000, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 3'd7, 8'h12, 8'h34, 7'b1000000, 8'h00, 1'b0, 1'b1};
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    reset = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'h33; req1_b = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_ctrl", alu_ctrl, 0);
    chk("reset_in1", alu_in1, 0);
    chk("reset_in2", alu_in2, 0);
    chk("reset_rsp", {rsp_id, rsp_data, rsp_overflow, rsp_err}, 0);
    $display("reset checked");

    // Contention: both requesters valid continuously.
    @(negedge clk);
    reset = 1'b1;
    drive_req(1'b0, 3'd0, 8'h01, 8'h01);
    drive_req(1'b1, 3'd2, 8'hFF, 8'h0F);
    #1;
    chk("cont_first_grant", {req0_ready, req1_ready}, 2'b10);
    got = 0; n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_ids[got] = rsp_id;
        $display("contention rsp %0d id=%b data=%h", got, rsp_id, rsp_data);
        got++;
      end
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_count", got, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_id%0d", i), got_ids[i], exp_ids[i]);
    @(posedge clk);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].ctrl, vecs[i].data, vecs[i].ov, vecs[i].err);

    // Backpressure: response held for 5 cycles, next request queued.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(1'b0, 3'd2, 8'hF0, 8'h3C);
    #1;
    wait_accept(1'b0);
    drive_req(1'b0, 3'd4, 8'h0F, 8'hF0);
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h30);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      req1_valid = ~req1_valid; req1_op = 3'd1;
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("bp_next_ctrl", alu_ctrl, 7'b0010000);
    chk("bp_next_in1", alu_in1, 8'h0F);
    @(posedge clk); #1;
    chk("bp_next_data", rsp_data, 8'hFF);
    $display("backpressure done");
    @(posedge clk);

    // Reset during EXEC discards the operation.
    @(negedge clk);
    drive_req(1'b0, 3'd3, 8'h81, 8'h18);
    #1;
    wait_accept(1'b0);
    req0_valid = 1'b0;
    chk("rst_exec_ctrl", alu_ctrl, 7'b0001000);
    reset = 1'b0;
    drive_req(1'b1, 3'd0, 8'h01, 8'h02);
    @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_in", {alu_in1, alu_in2}, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_overflow, rsp_err}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", rsp_valid, 0);
    end
    $display("reset mid-operation done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
